// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a program into RAM, optionally seeds the register file,
// waits a settle window, then releases the core. Build macro: BOOT_SEQ_REG_INIT_EN.
module boot_sequencer #(
   parameter int RAM_DATA_WIDTH = 32,
   parameter int RAM_ADDR_WIDTH = 16,
   parameter int BASE_ADDR      = 1,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int REG_DATA_WIDTH = 32,
   parameter int NUM_INIT_REGS  = 4,
   parameter int SETTLE_CYCLES  = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [RAM_ADDR_WIDTH-1:0] prog_len,
   input  logic                      halt,
   input  logic                      load_valid,
   input  logic [RAM_DATA_WIDTH-1:0] load_data,
   output logic                      load_ready,
   output logic                      ram_external_control_enable,
   output logic                      external_ram_enable,
   output logic                      external_ram_write_enable,
   output logic [RAM_ADDR_WIDTH-1:0] external_ram_addr,
   output logic [RAM_DATA_WIDTH-1:0] external_ram_write_data,
   output logic                      reg_external_control_enable,
   output logic                      external_write_enable,
   output logic [REG_ADDR_WIDTH-1:0] external_write_addr,
   output logic [REG_DATA_WIDTH-1:0] external_write_data,
   output logic                      core_reset,
   output logic                      ram_enable,
   output logic                      pc_enable,
   output logic                      control_enable,
   output logic                      busy,
   output logic [2:0]                state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_REG_INIT = 3'd2,
      S_SETTLE   = 3'd3,
      S_RUN      = 3'd4
   } state_t;

   // One counter serves both the register-init walk and the settle window.
   localparam int LP_CNT_MAX = (SETTLE_CYCLES > NUM_INIT_REGS) ? SETTLE_CYCLES : NUM_INIT_REGS;
   localparam int LP_CNT_W   = ($clog2(LP_CNT_MAX) < 1) ? 1 : $clog2(LP_CNT_MAX);
   localparam logic [RAM_ADDR_WIDTH-1:0] LP_BASE = RAM_ADDR_WIDTH'(BASE_ADDR);

   state_t                    r_state;
   logic                      r_busy;
   logic                      r_core_reset;
   logic                      r_run_en;
   logic                      r_load_ready;
   logic                      r_load_last;
   logic                      r_ram_ctrl;
   logic                      r_ram_we;
   logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
   logic [RAM_DATA_WIDTH-1:0] r_ram_wdata;
   logic [RAM_ADDR_WIDTH-1:0] r_prog_len;
   logic [RAM_ADDR_WIDTH-1:0] r_beat_cnt;
   logic [LP_CNT_W-1:0]       r_cnt;
`ifdef BOOT_SEQ_REG_INIT_EN
   logic                      r_reg_ctrl;
   logic                      r_reg_we;
   logic [REG_ADDR_WIDTH-1:0] r_reg_addr;
   logic [REG_DATA_WIDTH-1:0] r_reg_data;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_core_reset <= 1'b1;
         r_run_en     <= 1'b0;
         r_load_ready <= 1'b0;
         r_load_last  <= 1'b0;
         r_ram_ctrl   <= 1'b0;
         r_ram_we     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_wdata  <= '0;
         r_prog_len   <= '0;
         r_beat_cnt   <= '0;
         r_cnt        <= '0;
`ifdef BOOT_SEQ_REG_INIT_EN
         r_reg_ctrl   <= 1'b0;
         r_reg_we     <= 1'b0;
         r_reg_addr   <= '0;
         r_reg_data   <= '0;
`endif
      end else begin
         r_ram_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_prog_len  <= prog_len;
                  r_beat_cnt  <= '0;
                  r_load_last <= 1'b0;
                  r_busy      <= 1'b1;
                  r_cnt       <= '0;
                  if (prog_len != '0) begin
                     r_state      <= S_LOAD;
                     r_ram_ctrl   <= 1'b1;
                     r_load_ready <= 1'b1;
                  end else begin
`ifdef BOOT_SEQ_REG_INIT_EN
                     r_state    <= S_REG_INIT;
                     r_reg_ctrl <= 1'b1;
                     r_reg_we   <= 1'b1;
                     r_reg_addr <= '0;
                     r_reg_data <= '0;
`else
                     r_state    <= S_SETTLE;
`endif
                  end
               end
            end
            S_LOAD: begin
               // The final write is still on the bus this cycle; leave LOAD afterwards.
               if (r_load_last) begin
                  r_ram_ctrl  <= 1'b0;
                  r_load_last <= 1'b0;
                  r_cnt       <= '0;
`ifdef BOOT_SEQ_REG_INIT_EN
                  r_state    <= S_REG_INIT;
                  r_reg_ctrl <= 1'b1;
                  r_reg_we   <= 1'b1;
                  r_reg_addr <= '0;
                  r_reg_data <= '0;
`else
                  r_state    <= S_SETTLE;
`endif
               end else if (load_valid && r_load_ready) begin
                  r_ram_we    <= 1'b1;
                  r_ram_addr  <= LP_BASE + r_beat_cnt;
                  r_ram_wdata <= load_data;
                  r_beat_cnt  <= r_beat_cnt + RAM_ADDR_WIDTH'(1);
                  if (r_beat_cnt == r_prog_len - RAM_ADDR_WIDTH'(1)) begin
                     r_load_ready <= 1'b0;
                     r_load_last  <= 1'b1;
                  end
               end
            end
`ifdef BOOT_SEQ_REG_INIT_EN
            S_REG_INIT: begin
               if (r_cnt == LP_CNT_W'(NUM_INIT_REGS - 1)) begin
                  r_state    <= S_SETTLE;
                  r_reg_ctrl <= 1'b0;
                  r_reg_we   <= 1'b0;
                  r_cnt      <= '0;
               end else begin
                  r_cnt      <= r_cnt + LP_CNT_W'(1);
                  r_reg_addr <= r_reg_addr + REG_ADDR_WIDTH'(1);
                  r_reg_data <= REG_DATA_WIDTH'(r_reg_addr + REG_ADDR_WIDTH'(1));
               end
            end
`endif
            S_SETTLE: begin
               if (r_cnt == LP_CNT_W'(SETTLE_CYCLES - 1)) begin
                  r_state      <= S_RUN;
                  r_busy       <= 1'b0;
                  r_core_reset <= 1'b0;
                  r_run_en     <= 1'b1;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + LP_CNT_W'(1);
               end
            end
            S_RUN: begin
               if (halt) begin
                  r_state      <= S_IDLE;
                  r_core_reset <= 1'b1;
                  r_run_en     <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_core_reset <= 1'b1;
               r_run_en     <= 1'b0;
               r_load_ready <= 1'b0;
               r_ram_ctrl   <= 1'b0;
            end
         endcase
      end
   end

   assign state                       = r_state;
   assign busy                        = r_busy;
   assign core_reset                  = r_core_reset;
   assign ram_enable                  = r_run_en;
   assign pc_enable                   = r_run_en;
   assign control_enable              = r_run_en;
   assign load_ready                  = r_load_ready;
   assign ram_external_control_enable = r_ram_ctrl;
   assign external_ram_enable         = r_ram_ctrl;
   assign external_ram_write_enable   = r_ram_we;
   assign external_ram_addr           = r_ram_addr;
   assign external_ram_write_data     = r_ram_wdata;
`ifdef BOOT_SEQ_REG_INIT_EN
   assign reg_external_control_enable = r_reg_ctrl;
   assign external_write_enable       = r_reg_we;
   assign external_write_addr         = r_reg_addr;
   assign external_write_data         = r_reg_data;
`else
   assign reg_external_control_enable = 1'b0;
   assign external_write_enable       = 1'b0;
   assign external_write_addr         = '0;
   assign external_write_data         = '0;
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized bench for boot_sequencer: expected traces are derived from the beat
// schedule (which edges carry beats) rather than from the state machine itself.
module tb_boot_sequencer;
   localparam int AW = 16, DW = 32, RAW = 5, RDW = 32, NREG = 4, SETTLE = 2, BASE = 1;
`ifdef BOOT_SEQ_REG_INIT_EN
   localparam int NEXP = NREG;
`else
   localparam int NEXP = 0;
`endif

   logic clk = 1'b0;
   logic reset, start, halt, load_valid;
   logic [AW-1:0] prog_len;
   logic [DW-1:0] load_data;
   logic load_ready, ram_ctrl, ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic reg_ctrl, reg_we;
   logic [RAW-1:0] reg_addr;
   logic [RDW-1:0] reg_data;
   logic core_reset, run_ram, run_pc, run_ctl, busy;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   bit            vpat [64];
   logic [DW-1:0] dpat [64];

   always #5 clk = ~clk;

   boot_sequencer #(
      .RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .BASE_ADDR(BASE),
      .REG_ADDR_WIDTH(RAW), .REG_DATA_WIDTH(RDW), .NUM_INIT_REGS(NREG),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .halt(halt),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .ram_external_control_enable(ram_ctrl), .external_ram_enable(ram_en),
      .external_ram_write_enable(ram_we), .external_ram_addr(ram_addr),
      .external_ram_write_data(ram_wdata),
      .reg_external_control_enable(reg_ctrl), .external_write_enable(reg_we),
      .external_write_addr(reg_addr), .external_write_data(reg_data),
      .core_reset(core_reset), .ram_enable(run_ram), .pc_enable(run_pc),
      .control_enable(run_ctl), .busy(busy), .state(state)
   );

   // Boots one program; mode 0 = every cycle valid, 1 = two-cycle gaps, 2 = random.
   task automatic run_boot(input int plen, input int mode, input int inj_t, input string name);
      int bedge[$];
      int bl, ri, rn, ntot, e_st;
      logic e_we, e_rdy, e_rwe, e_rst, e_run;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      vpat[0] = 1'b0;
      dpat[0] = '0;
      for (int i = 1; i < 64; i++) begin
         case (mode)
            0:       vpat[i] = 1'b1;
            1:       vpat[i] = ((i - 1) % 3 == 0);
            default: vpat[i] = (i > 30) ? 1'b1 : ($urandom_range(0, 1) == 1);
         endcase
         dpat[i] = $urandom;
      end
      for (int i = 1; i < 64; i++)
         if (vpat[i] && bedge.size() < plen) bedge.push_back(i);
      bl   = (plen > 0) ? bedge[plen-1] : -1;
      ri   = (plen > 0) ? bl + 1 : 0;
      rn   = ri + NEXP + SETTLE;
      ntot = rn + 2;

      @(negedge clk);
      start = 1'b1; prog_len = AW'(plen); load_valid = 1'b0;
      for (int t = 0; t < ntot; t++) begin
         @(negedge clk);
         e_we = 1'b0; e_addr = '0; e_data = '0;
         for (int j = 0; j < bedge.size(); j++)
            if (bedge[j] == t) begin
               e_we = 1'b1; e_addr = AW'(BASE + j); e_data = dpat[t];
            end
         e_st  = (t >= rn) ? 4 : (t >= ri + NEXP) ? 3 : (t >= ri) ? 2 : 1;
         e_rdy = (t < bl);
         e_rwe = (t >= ri) && (t < ri + NEXP);
         e_rst = (t < rn);
         e_run = (t >= rn);

         total++;
         if (state !== 3'(e_st) || busy !== e_rst) begin
            bad++;
            $display("FAIL %s state c%0d: got st=%0d busy=%b want st=%0d busy=%b", name, t, state, busy, e_st, e_rst);
         end
         total++;
         if (core_reset !== e_rst || {run_ram, run_pc, run_ctl} !== {3{e_run}}) begin
            bad++;
            $display("FAIL %s core c%0d: got rst=%b en=%b%b%b want rst=%b en=%b", name, t, core_reset, run_ram, run_pc, run_ctl, e_rst, e_run);
         end
         total++;
         if (ram_we !== e_we || (e_we && (ram_addr !== e_addr || ram_wdata !== e_data))) begin
            bad++;
            $display("FAIL %s ramwr c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h", name, t, ram_we, ram_addr, ram_wdata, e_we, e_addr, e_data);
         end
         total++;
         if (load_ready !== e_rdy || ram_ctrl !== (e_st == 1) || ram_en !== (e_st == 1)) begin
            bad++;
            $display("FAIL %s ldctl c%0d: got rdy=%b ctl=%b en=%b want rdy=%b ctl=%b", name, t, load_ready, ram_ctrl, ram_en, e_rdy, (e_st == 1));
         end
         total++;
         if (reg_we !== e_rwe || reg_ctrl !== e_rwe ||
             (e_rwe && (reg_addr !== RAW'(t - ri) || reg_data !== RDW'(t - ri)))) begin
            bad++;
            $display("FAIL %s regwr c%0d: got we=%b ctl=%b a=%0d d=%0d want we=%b idx=%0d", name, t, reg_we, reg_ctrl, reg_addr, reg_data, e_rwe, t - ri);
         end
         start      = (t + 1 == inj_t);
         prog_len   = AW'($urandom_range(0, 40));
         load_valid = vpat[t+1];
         load_data  = dpat[t+1];
      end
      start = 1'b0; load_valid = 1'b0;

      // start in RUN must be ignored
      start = 1'b1; prog_len = AW'(5);
      @(negedge clk);
      start = 1'b0;
      total++;
      if (state !== 3'd4 || core_reset !== 1'b0) begin
         bad++;
         $display("FAIL %s run_start: got st=%0d rst=%b want st=4 rst=0", name, state, core_reset);
      end
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      total++;
      if (state !== 3'd0 || core_reset !== 1'b1 || {run_ram, run_pc, run_ctl, busy} !== 4'b0) begin
         bad++;
         $display("FAIL %s halt: got st=%0d rst=%b en=%b%b%b busy=%b want st=0 rst=1 en=000", name, state, core_reset, run_ram, run_pc, run_ctl, busy);
      end
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      total++;
      if (state !== 3'd0 || core_reset !== 1'b1) begin
         bad++;
         $display("FAIL %s idle_halt: got st=%0d rst=%b want st=0 rst=1", name, state, core_reset);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; halt = 1'b0; load_valid = 1'b0;
      prog_len = '0; load_data = '0;
      repeat (3) @(negedge clk);
      total++;
      if (state !== 3'd0 || core_reset !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0 ||
          {ram_ctrl, ram_en, ram_we, reg_ctrl, reg_we, run_ram, run_pc, run_ctl} !== 8'b0) begin
         bad++;
         $display("FAIL reset: got st=%0d rst=%b busy=%b rdy=%b want st=0 rst=1 others 0", state, core_reset, busy, load_ready);
      end
      reset = 1'b1;
   endtask

   task automatic test_back_to_back();
      run_boot(6, 0, -1, "b2b");
   endtask

   task automatic test_gaps();
      run_boot(3, 1, -1, "gaps");
   endtask

   task automatic test_zero_len();
      run_boot(0, 0, -1, "zero");
   endtask

   task automatic test_start_in_load();
      run_boot(4, 2, 2, "ldstart");
   endtask

   task automatic test_random();
      for (int n = 0; n < 5; n++)
         run_boot($urandom_range(1, 8), 2, $urandom_range(1, 6), "rand");
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      start = 1'b1; prog_len = AW'(5); load_valid = 1'b0;
      @(negedge clk);
      start = 1'b0; load_valid = 1'b1; load_data = 32'hA1;
      @(negedge clk);
      load_data = 32'hA2;
      @(negedge clk);
      load_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      total++;
      if (state !== 3'd0 || core_reset !== 1'b1 || load_ready !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0) begin
         bad++;
         $display("FAIL midreset: got st=%0d rst=%b rdy=%b busy=%b we=%b want st=0 rst=1 rdy=0", state, core_reset, load_ready, busy, ram_we);
      end
      @(negedge clk);
      reset = 1'b1;
      run_boot(3, 0, -1, "reload");
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_zero_len();
      test_start_in_load();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
